// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2,
      ST_HALT = 2'd3
   } ifu_state_e;

   localparam logic [31:0] INSTR_EBREAK     = 32'h0010_0073;
   localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_perf_cnt.sv
// Free-running wrap-around event counter with synchronous clear.
module ifu_perf_cnt #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/ifu_fetch.sv
// RV32 instruction fetch: owns the PC, single outstanding imem read, valid/ready to decode.
// Optional retired-fetch counter on fetch_cnt when IFU_PERF_EN is defined.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter int unsigned          XLEN     = 32,
   parameter logic [XLEN-1:0]      RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_instr,
`ifdef IFU_PERF_EN
   output logic            halted,
   output logic [31:0]     fetch_cnt
`else
   output logic            halted
`endif
);

   ifu_state_e      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            drop_q, drop_d;
   logic [XLEN-1:0] out_pc_q, out_pc_d;
   logic [XLEN-1:0] out_instr_q, out_instr_d;

   logic [XLEN-1:0] redir_pc;
   logic [1:0]      redirect_lsb_unused;

   assign redir_pc            = {redirect_pc[XLEN-1:2], 2'b00};
   assign redirect_lsb_unused = redirect_pc[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_REQ;
         pc_q        <= RESET_PC;
         drop_q      <= 1'b0;
         out_pc_q    <= '0;
         out_instr_q <= XLEN'(INSTR_NOP);
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_q      <= drop_d;
         out_pc_q    <= out_pc_d;
         out_instr_q <= out_instr_d;
      end
   end

   // Redirect outranks every other event except in HALT.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_d      = drop_q;
      out_pc_d    = out_pc_q;
      out_instr_d = out_instr_q;
      case (state_q)
         ST_REQ: begin
            if (redirect_valid) begin
               pc_d = redir_pc;
               if (imem_req_ready) begin
                  drop_d  = 1'b1;
                  state_d = ST_WAIT;
               end
            end else if (imem_req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (redirect_valid) begin
               pc_d = redir_pc;
               if (imem_rsp_valid) begin
                  drop_d  = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  drop_d = 1'b1;
               end
            end else if (imem_rsp_valid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  out_pc_d    = pc_q;
                  out_instr_d = imem_rsp_data;
                  state_d     = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               pc_d    = redir_pc;
               state_d = ST_REQ;
            end else if (out_ready) begin
               pc_d    = pc_q + XLEN'(4);
               state_d = (out_instr_q == XLEN'(INSTR_EBREAK)) ? ST_HALT : ST_REQ;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_REQ;
         end
      endcase
   end

   assign imem_req_valid = (state_q == ST_REQ);
   assign imem_req_addr  = pc_q;
   assign out_valid      = (state_q == ST_HOLD);
   assign out_pc         = out_pc_q;
   assign out_instr      = out_instr_q;
   assign halted         = (state_q == ST_HALT);

`ifdef IFU_PERF_EN
   logic hs_c;
   assign hs_c = (state_q == ST_HOLD) && out_ready && !redirect_valid;

   ifu_perf_cnt #(.W(32)) u_perf_cnt (
      .clk   (clk),
      .clr_i (rst),
      .en_i  (hs_c),
      .cnt_o (fetch_cnt)
   );
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: normal fetch, stalls, redirects, ebreak halt and resets.
module tb_ifu_fetch;
   import ifu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        halted;
   logic [31:0] fetch_cnt;

   int          tests_run = 0;
   int          tests_failed = 0;
   logic [31:0] exp_cnt = '0;

   always #5 clk = ~clk;

   ifu_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
`ifdef IFU_PERF_EN
      .halted         (halted),
      .fetch_cnt      (fetch_cnt)
`else
      .halted         (halted)
`endif
   );

`ifndef IFU_PERF_EN
   assign fetch_cnt = '0;
`endif

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag);
`ifdef IFU_PERF_EN
      chk(tag, fetch_cnt, exp_cnt);
`endif
   endtask

   task automatic chk_reset_vals();
      chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
      chk("rst_req_addr", imem_req_addr, 32'h8000_0000);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_instr", out_instr, 32'h0000_0013);
      chk("rst_halted", 32'(halted), 32'd0);
      chk_cnt("rst_fetch_cnt");
   endtask

   // One full zero-wait fetch starting in REQ; optionally hand the pair off.
   task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input bit hs);
      chk("req_valid", 32'(imem_req_valid), 32'd1);
      chk("req_addr", imem_req_addr, addr);
      imem_req_ready = 1'b1;
      cyc();
      imem_req_ready = 1'b0;
      chk("wait_out_valid", 32'(out_valid), 32'd0);
      chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      cyc();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_pc", out_pc, addr);
      chk("hold_out_instr", out_instr, data);
      chk("hold_req_valid", 32'(imem_req_valid), 32'd0);
      if (hs) begin
         out_ready = 1'b1;
         cyc();
         out_ready = 1'b0;
         exp_cnt   = exp_cnt + 32'd1;
      end
   endtask

   initial begin
      rst            = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b0;
      repeat (3) cyc();
      chk_reset_vals();
      rst = 1'b0;
      cyc();
      chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);

      // Back-to-back fetches, each request 3 cycles after the previous one
      fetch(32'h8000_0000, 32'h0000_0093, 1'b1);
      fetch(32'h8000_0004, 32'h0010_0113, 1'b1);
      fetch(32'h8000_0008, 32'h0020_0193, 1'b1);
      chk_cnt("cnt_after_3");

      // Decode stalls 5 cycles in HOLD
      fetch(32'h8000_000C, 32'h00C0_0213, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_out_pc", out_pc, 32'h8000_000C);
         chk("stall_out_instr", out_instr, 32'h00C0_0213);
         chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      exp_cnt   = exp_cnt + 32'd1;
      chk("stall_release_addr", imem_req_addr, 32'h8000_0010);
      chk_cnt("cnt_after_stall");

      // Redirect while waiting: stale ebreak word must be discarded
      chk("rw_req_valid", 32'(imem_req_valid), 32'd1);
      imem_req_ready = 1'b1;
      cyc();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0103;
      cyc();
      redirect_valid = 1'b0;
      chk("rw_still_wait", 32'(imem_req_valid), 32'd0);
      chk("rw_out_valid0", 32'(out_valid), 32'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = INSTR_EBREAK;
      cyc();
      imem_rsp_valid = 1'b0;
      chk("rw_out_valid1", 32'(out_valid), 32'd0);
      chk("rw_halted", 32'(halted), 32'd0);
      fetch(32'h8000_0100, 32'h0050_0293, 1'b1);

      // Redirect in REQ coincident with the handshake: in-flight response dropped
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0200;
      imem_req_ready = 1'b1;
      cyc();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b0;
      chk("rr_wait", 32'(imem_req_valid), 32'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h1234_5678;
      cyc();
      imem_rsp_valid = 1'b0;
      chk("rr_out_valid", 32'(out_valid), 32'd0);

      // Redirect in HOLD with out_ready high: no handoff
      fetch(32'h8000_0200, 32'h0060_0313, 1'b0);
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      cyc();
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      chk("rh_out_valid", 32'(out_valid), 32'd0);
      chk("rh_req_valid", 32'(imem_req_valid), 32'd1);
      chk_cnt("rh_cnt_unchanged");

      // PC wraps from the top of the address space
      fetch(32'hFFFF_FFFC, 32'h0000_0033, 1'b1);
      chk("wrap_addr", imem_req_addr, 32'h0000_0000);

      // Redirect in REQ without handshake just retargets the request
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0010;
      cyc();
      redirect_valid = 1'b0;

      // ebreak handed off once, then halt
      fetch(32'h8000_0010, INSTR_EBREAK, 1'b1);
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_req_valid", 32'(imem_req_valid), 32'd0);
      chk("halt_out_valid", 32'(out_valid), 32'd0);
      chk_cnt("halt_cnt");
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0000;
      imem_rsp_valid = 1'b1;
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      repeat (3) cyc();
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b0;
      out_ready      = 1'b0;
      chk("halt_stays", 32'(halted), 32'd1);
      chk("halt_no_req", 32'(imem_req_valid), 32'd0);
      chk("halt_pc_kept", imem_req_addr, 32'h8000_0014);
      chk_cnt("halt_cnt_kept");

      // Reset leaves HALT
      rst = 1'b1;
      cyc();
      exp_cnt = '0;
      chk_reset_vals();
      rst = 1'b0;

      // Reset while WAIT, with the old response arriving afterwards
      imem_req_ready = 1'b1;
      cyc();
      imem_req_ready = 1'b0;
      chk("rwt_wait", 32'(imem_req_valid), 32'd0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk_reset_vals();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = INSTR_EBREAK;
      cyc();
      imem_rsp_valid = 1'b0;
      chk("rwt_out_valid", 32'(out_valid), 32'd0);
      chk("rwt_req_valid", 32'(imem_req_valid), 32'd1);
      chk("rwt_req_addr", imem_req_addr, 32'h8000_0000);
      fetch(32'h8000_0000, 32'h0070_0393, 1'b1);
      chk_cnt("final_cnt");
      chk("final_addr", imem_req_addr, 32'h8000_0004);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
